tablero_ttt: RTL and testbench

Board-state and move-evaluation stage for the tic-tac-toe game. It sits directly upstream of the game-control state machine and accepts cell-select move requests. It keeps the 3x3 board and the turn, and decides whether each move is legal. It produces the level signals the controller consumes: `movimientoIlegal`, `noEspacio` and `gane`, plus the board image for the display path.

---
 rtl/tablero_pkg.sv | 29 ++
 rtl/detector_linea.sv | 30 +++
 rtl/tablero_ttt.sv | 135 +++++++++++++
 tb/tb_tablero_ttt.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/tablero_pkg.sv
// Shared definitions for the tic-tac-toe board stage: cell codes, FSM states, winning lines.
package tablero_pkg;

  localparam logic [1:0] VACIA   = 2'b00;
  localparam logic [1:0] CRUZ    = 2'b01;
  localparam logic [1:0] CIRCULO = 2'b10;

  typedef enum logic [1:0] {
    LIBRE  = 2'd0,
    EVALUA = 2'd1,
    FIN    = 2'd2
  } estado_e;

  localparam int NumLineas = 8;

  // Rows, columns, then the two diagonals (row-major cell numbering).
  localparam int unsigned LINEAS [NumLineas][3] = '{
    '{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8},
    '{0, 3, 6}, '{1, 4, 7}, '{2, 5, 8},
    '{0, 4, 8}, '{2, 4, 6}
  };

  // Returns the 2-bit code of cell idx; out-of-board indices read as empty.
  function automatic logic [1:0] celda(input logic [17:0] tab, input int unsigned idx);
    if (idx > 8) return VACIA;
    return tab[2*idx +: 2];
  endfunction

endpackage

// File: rtl/detector_linea.sv
// Combinational three-in-a-row detector over the 3x3 board image.
module detector_linea
  import tablero_pkg::*;
(
  input  logic [17:0] tablero,
  output logic        gane,
  output logic [1:0]  ganador
);

  logic [1:0] a, b, c;

  // Scan all eight lines for three equal occupied cells.
  always_comb begin
    gane    = 1'b0;
    ganador = VACIA;
    a       = VACIA;
    b       = VACIA;
    c       = VACIA;
    for (int i = 0; i < NumLineas; i++) begin
      a = celda(tablero, LINEAS[i][0]);
      b = celda(tablero, LINEAS[i][1]);
      c = celda(tablero, LINEAS[i][2]);
      if (a != VACIA && a == b && a == c) begin
        gane    = 1'b1;
        ganador = a;
      end
    end
  end

endmodule

// File: rtl/tablero_ttt.sv
// Board state, turn tracking and move evaluation for the tic-tac-toe controller.
module tablero_ttt
  import tablero_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        mov_valid,
  input  logic [3:0]  mov_celda,
  input  logic        mov_jugador,
  output logic        mov_listo,
  output logic        movimientoIlegal,
  output logic        noEspacio,
  output logic        gane,
  output logic [1:0]  ganador,
  output logic [17:0] tablero,
  output logic [3:0]  movimientos
);

  estado_e     estado_q, estado_d;
  logic [17:0] tablero_q, tablero_d;
  logic [3:0]  movs_q, movs_d;
  logic        turno_q, turno_d;
  logic        pend_q, pend_d;
  logic        ilegal_q, ilegal_d;
  logic        gane_q, gane_d;
  logic [1:0]  ganador_q, ganador_d;
  logic        noesp_q, noesp_d;
  logic        listo_q, listo_d;

  logic        det_gane;
  logic [1:0]  det_ganador;
  logic        legal;
  logic        lleno;

  detector_linea u_detector (
    .tablero (tablero_q),
    .gane    (det_gane),
    .ganador (det_ganador)
  );

  assign lleno = (movs_q == 4'd9);

  // Next-state: accept/evaluate moves; clear overrides everything.
  always_comb begin
    estado_d  = estado_q;
    tablero_d = tablero_q;
    movs_d    = movs_q;
    turno_d   = turno_q;
    pend_d    = pend_q;
    ilegal_d  = ilegal_q;
    gane_d    = gane_q;
    ganador_d = ganador_q;
    noesp_d   = noesp_q;
    listo_d   = 1'b0;
    legal     = 1'b0;

    if (clear) begin
      estado_d  = LIBRE;
      tablero_d = '0;
      movs_d    = '0;
      turno_d   = 1'b0;
      pend_d    = 1'b0;
      ilegal_d  = 1'b0;
      gane_d    = 1'b0;
      ganador_d = VACIA;
      noesp_d   = 1'b0;
    end else begin
      case (estado_q)
        LIBRE, FIN: begin
          if (mov_valid) begin
            legal = (estado_q == LIBRE) && (mov_celda <= 4'd8) &&
                    (celda(tablero_q, {28'd0, mov_celda}) == VACIA) &&
                    (mov_jugador == turno_q);
            if (legal) begin
              for (int k = 0; k < 9; k++) begin
                if (mov_celda == 4'(k)) tablero_d[2*k +: 2] = mov_jugador ? CIRCULO : CRUZ;
              end
              movs_d  = movs_q + 4'd1;
              turno_d = ~turno_q;
            end
            pend_d   = ~legal;
            estado_d = EVALUA;
          end
        end
        EVALUA: begin
          ilegal_d  = pend_q;
          gane_d    = det_gane;
          ganador_d = det_ganador;
          noesp_d   = lleno;
          listo_d   = 1'b1;
          // An illegal move taken from FIN leaves the board unchanged, so this re-enters FIN.
          estado_d  = (det_gane || lleno) ? FIN : LIBRE;
        end
        default: estado_d = LIBRE;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q  <= LIBRE;
      tablero_q <= '0;
      movs_q    <= '0;
      turno_q   <= 1'b0;
      pend_q    <= 1'b0;
      ilegal_q  <= 1'b0;
      gane_q    <= 1'b0;
      ganador_q <= VACIA;
      noesp_q   <= 1'b0;
      listo_q   <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      tablero_q <= tablero_d;
      movs_q    <= movs_d;
      turno_q   <= turno_d;
      pend_q    <= pend_d;
      ilegal_q  <= ilegal_d;
      gane_q    <= gane_d;
      ganador_q <= ganador_d;
      noesp_q   <= noesp_d;
      listo_q   <= listo_d;
    end
  end

  assign mov_listo        = listo_q;
  assign movimientoIlegal = ilegal_q;
  assign noEspacio        = noesp_q;
  assign gane             = gane_q;
  assign ganador          = ganador_q;
  assign tablero          = tablero_q;
  assign movimientos      = movs_q;

endmodule

// File: tb/tb_tablero_ttt.sv
// Randomized self-checking bench for tablero_ttt against a game-level reference model.
module tb_tablero_ttt;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        mov_valid = 1'b0;
  logic [3:0]  mov_celda = '0;
  logic        mov_jugador = 1'b0;
  logic        mov_listo;
  logic        movimientoIlegal;
  logic        noEspacio;
  logic        gane;
  logic [1:0]  ganador;
  logic [17:0] tablero;
  logic [3:0]  movimientos;

  tablero_ttt dut (
    .clk              (clk),
    .rst              (rst),
    .clear            (clear),
    .mov_valid        (mov_valid),
    .mov_celda        (mov_celda),
    .mov_jugador      (mov_jugador),
    .mov_listo        (mov_listo),
    .movimientoIlegal (movimientoIlegal),
    .noEspacio        (noEspacio),
    .gane             (gane),
    .ganador          (ganador),
    .tablero          (tablero),
    .movimientos      (movimientos)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: board as 0 empty / 1 player 1 / 2 player 2.
  int b [9];
  int turn;
  int cnt;
  bit over;
  bit e_il, e_gane, e_noesp;
  int e_gan;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 9; k++) b[k] = 0;
    turn = 0; cnt = 0; over = 0;
    e_il = 0; e_gane = 0; e_noesp = 0; e_gan = 0;
  endtask

  function automatic logic [17:0] pack_board();
    logic [17:0] t;
    t = '0;
    for (int k = 0; k < 9; k++) t[2*k +: 2] = 2'(b[k]);
    return t;
  endfunction

  function automatic int winner();
    int w;
    w = 0;
    for (int r = 0; r < 3; r++)
      if (b[3*r] != 0 && b[3*r] == b[3*r+1] && b[3*r] == b[3*r+2]) w = b[3*r];
    for (int c = 0; c < 3; c++)
      if (b[c] != 0 && b[c] == b[c+3] && b[c] == b[c+6]) w = b[c];
    if (b[4] != 0 && b[0] == b[4] && b[8] == b[4]) w = b[4];
    if (b[4] != 0 && b[2] == b[4] && b[6] == b[4]) w = b[4];
    return w;
  endfunction

  task automatic check_flags(input string tag);
    check({tag, "_ilegal"}, 32'(movimientoIlegal), 32'(e_il));
    check({tag, "_gane"}, 32'(gane), 32'(e_gane));
    check({tag, "_ganador"}, 32'(ganador), 32'(e_gan));
    check({tag, "_noesp"}, 32'(noEspacio), 32'(e_noesp));
  endtask

  task automatic check_all(input string tag);
    check({tag, "_tab"}, 32'(tablero), 32'(pack_board()));
    check({tag, "_movs"}, 32'(movimientos), 32'(cnt));
    check_flags(tag);
  endtask

  // mode 0: normal, 1: clear during evaluation, 2: reset during evaluation.
  task automatic send_move(input int cel, input int jug, input int mode);
    bit legal;
    int w;
    @(negedge clk);
    mov_valid = 1'b1; mov_celda = 4'(cel); mov_jugador = jug[0];
    legal = 0;
    if (!over && cel <= 8 && jug == turn) legal = (b[cel] == 0);
    if (legal) begin
      b[cel] = jug + 1; cnt++; turn ^= 1;
    end
    @(negedge clk);
    mov_valid = 1'b0;
    check_all("n1");
    check("n1_listo", 32'(mov_listo), 32'd0);
    if (mode == 1) begin
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model_clear();
      check("clr_listo", 32'(mov_listo), 32'd0);
      check_all("clr");
      @(negedge clk);
      check("clr_listo2", 32'(mov_listo), 32'd0);
      return;
    end
    if (mode == 2) begin
      rst = 1'b1;
      #1;
      model_clear();
      check_all("rst_mid");
      check("rst_listo", 32'(mov_listo), 32'd0);
      @(negedge clk);
      check("rst_listo2", 32'(mov_listo), 32'd0);
      rst = 1'b0;
      @(negedge clk);
      check("rst_listo3", 32'(mov_listo), 32'd0);
      return;
    end
    w = winner();
    e_il = !legal; e_gane = (w != 0); e_gan = w; e_noesp = (cnt == 9);
    over = e_gane || e_noesp;
    @(negedge clk);
    check("n2_listo", 32'(mov_listo), 32'd1);
    check_all("n2");
  endtask

  task automatic clear_with_move(input int cel, input int jug);
    @(negedge clk);
    clear = 1'b1; mov_valid = 1'b1; mov_celda = 4'(cel); mov_jugador = jug[0];
    @(negedge clk);
    clear = 1'b0; mov_valid = 1'b0;
    model_clear();
    check_all("cwm");
    check("cwm_listo", 32'(mov_listo), 32'd0);
    @(negedge clk);
    check("cwm_listo2", 32'(mov_listo), 32'd0);
    check_all("cwm2");
  endtask

  initial begin
    int cel, jug, pick, nfree;
    int libres [$];
    model_clear();
    repeat (3) @(negedge clk);
    check_all("rst");
    check("rst_listo", 32'(mov_listo), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_all("rel");
    check("rel_listo", 32'(mov_listo), 32'd0);

    // Directed: occupied cell, recovery, out of turn, invalid cell.
    send_move(4, 0, 0);
    check("p1_c4", 32'(tablero[9:8]), 32'd1);
    send_move(4, 1, 0);
    check("occ_ilegal", 32'(movimientoIlegal), 32'd1);
    send_move(0, 1, 0);
    check("rec_ilegal", 32'(movimientoIlegal), 32'd0);
    send_move(1, 1, 0);
    send_move(9, 0, 0);
    check("c9_ilegal", 32'(movimientoIlegal), 32'd1);

    // P1 wins on the top row, then a move in FIN.
    clear_with_move(5, 0);
    send_move(0, 0, 0); send_move(3, 1, 0); send_move(1, 0, 0);
    send_move(4, 1, 0); send_move(2, 0, 0);
    check("win_ganador", 32'(ganador), 32'd1);
    send_move(8, 1, 0);
    check("fin_gane", 32'(gane), 32'd1);

    // Draw.
    clear_with_move(0, 0);
    send_move(0, 0, 0); send_move(1, 1, 0); send_move(2, 0, 0);
    send_move(4, 1, 0); send_move(3, 0, 0); send_move(5, 1, 0);
    send_move(7, 0, 0); send_move(6, 1, 0); send_move(8, 0, 0);
    check("draw_noesp", 32'(noEspacio), 32'd1);
    check("draw_movs", 32'(movimientos), 32'd9);

    // Clear during evaluation, then a normal first move.
    clear_with_move(0, 0);
    send_move(2, 0, 0);
    send_move(6, 1, 1);
    send_move(4, 0, 0);
    check("post_clr_ilegal", 32'(movimientoIlegal), 32'd0);

    // Reset during evaluation.
    send_move(8, 1, 2);

    // Randomized play.
    for (int it = 0; it < 400; it++) begin
      pick = $urandom_range(0, 39);
      if (over && $urandom_range(0, 1) == 0) begin
        clear_with_move($urandom_range(0, 8), $urandom_range(0, 1));
        continue;
      end
      libres.delete();
      for (int k = 0; k < 9; k++) if (b[k] == 0) libres.push_back(k);
      nfree = libres.size();
      if (nfree > 0 && $urandom_range(0, 3) != 0) cel = libres[$urandom_range(0, nfree - 1)];
      else cel = $urandom_range(0, 11);
      jug = ($urandom_range(0, 9) < 8) ? turn : (turn ^ 1);
      if (pick == 0) send_move(cel, jug, 1);
      else if (pick == 1) send_move(cel, jug, 2);
      else send_move(cel, jug, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
